// File: rtl/bus_master.sv
// Single-outstanding Wishbone master: one client request in, one bus cycle out, one done pulse back.
// A request is taken only in IDLE; each transfer ends with a one-cycle strobe-low RELEASE before IDLE.
module bus_master #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 req_we_i,
  input  logic [ADR_WIDTH-1:0] req_adr_i,
  input  logic [DAT_WIDTH-1:0] req_dat_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 done_err_o,
  output logic                 done_timeout_o,
  output logic [DAT_WIDTH-1:0] rd_dat_o,
  output logic [ADR_WIDTH-1:0] mst_adr_o,
  output logic [DAT_WIDTH-1:0] mst_dat_o,
  input  logic [DAT_WIDTH-1:0] mst_dat_i,
  output logic                 mst_we_o,
  output logic                 mst_stb_o,
  output logic                 mst_cyc_o,
  input  logic                 mst_ack_i,
  input  logic                 mst_err_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_ACCESS,
    STATE_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic [DAT_WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic                 we_q, we_d;
  logic                 act_q, act_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 done_err_q, done_err_d;
  logic                 done_to_q, done_to_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;

  // The counter value after this cycle; reaching TIMEOUT means TIMEOUT cycles of strobe have elapsed.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    act_d      = act_q;
    busy_d     = busy_q;
    rd_dat_d   = rd_dat_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    done_to_d  = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (req_i) begin
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
          we_d    = req_we_i;
          act_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = STATE_ACCESS;
        end
      end
      STATE_ACCESS: begin
        cnt_d = cnt_inc;
        // err outranks ack, and either outranks a timeout landing on the same edge
        if (mst_err_i) begin
          act_d      = 1'b0;
          done_d     = 1'b1;
          done_err_d = 1'b1;
          state_d    = STATE_RELEASE;
        end else if (mst_ack_i) begin
          act_d   = 1'b0;
          done_d  = 1'b1;
          state_d = STATE_RELEASE;
          if (!we_q) begin
            rd_dat_d = mst_dat_i;
          end
        end else if (cnt_inc == CNT_MAX) begin
          act_d      = 1'b0;
          done_d     = 1'b1;
          done_err_d = 1'b1;
          done_to_d  = 1'b1;
          state_d    = STATE_RELEASE;
        end
      end
      STATE_RELEASE: begin
        busy_d  = 1'b0;
        state_d = STATE_IDLE;
      end
      default: begin
        act_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= STATE_IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      act_q      <= 1'b0;
      busy_q     <= 1'b0;
      rd_dat_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      done_to_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      act_q      <= act_d;
      busy_q     <= busy_d;
      rd_dat_q   <= rd_dat_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      done_to_q  <= done_to_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign done_err_o     = done_err_q;
  assign done_timeout_o = done_to_q;
  assign rd_dat_o       = rd_dat_q;
  assign mst_adr_o      = adr_q;
  assign mst_dat_o      = dat_q;
  assign mst_we_o       = we_q;
  assign mst_stb_o      = act_q;
  assign mst_cyc_o      = act_q;

endmodule

// File: tb/tb_bus_master.sv
// Randomized bench for bus_master with a Wishbone slave model and a transaction-level outcome model.
module tb_bus_master;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int TO = 8;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i, req_we_i;
  logic [AW-1:0] req_adr_i;
  logic [DW-1:0] req_dat_i;
  logic          busy_o, done_o, done_err_o, done_timeout_o;
  logic [DW-1:0] rd_dat_o, mst_dat_o, mst_dat_i;
  logic [AW-1:0] mst_adr_o;
  logic          mst_we_o, mst_stb_o, mst_cyc_o;
  logic          mst_ack_i, mst_err_i;

  int            n_pass = 0;
  int            n_chk  = 0;
  logic [DW-1:0] rd_exp = '0;

  int            s_mode = M_ACK;
  int            s_wait = 0;
  logic [DW-1:0] s_rdat = '0;
  int            s_cnt  = 0;

  always #5 clk = ~clk;

  bus_master #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .busy_o(busy_o), .done_o(done_o),
    .done_err_o(done_err_o), .done_timeout_o(done_timeout_o), .rd_dat_o(rd_dat_o),
    .mst_adr_o(mst_adr_o), .mst_dat_o(mst_dat_o), .mst_dat_i(mst_dat_i),
    .mst_we_o(mst_we_o), .mst_stb_o(mst_stb_o), .mst_cyc_o(mst_cyc_o),
    .mst_ack_i(mst_ack_i), .mst_err_i(mst_err_i)
  );

  // Registered slave: answers after s_wait extra cycles of strobe, or never.
  assign mst_dat_i = s_rdat;
  always @(posedge clk) begin
    if (mst_stb_o && mst_cyc_o && !mst_ack_i && !mst_err_i) begin
      if (s_cnt == s_wait && s_mode != M_NONE) begin
        mst_ack_i <= (s_mode == M_ACK) || (s_mode == M_BOTH);
        mst_err_i <= (s_mode == M_ERR) || (s_mode == M_BOTH);
        s_cnt     <= 0;
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      mst_ack_i <= 1'b0;
      mst_err_i <= 1'b0;
      if (!mst_stb_o) s_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wdat,
                         input int mode, input int w, input logic [DW-1:0] sdat);
    logic exp_to, exp_err;
    int   k_exp, k, stb_cycles;
    exp_to  = (mode == M_NONE) || (2 + w > TO);
    k_exp   = exp_to ? TO : 2 + w;
    exp_err = exp_to || (mode == M_ERR) || (mode == M_BOTH);
    if (!we && !exp_err) rd_exp = sdat;

    @(negedge clk);
    s_mode = mode; s_wait = w; s_rdat = sdat;
    req_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = wdat;
    @(posedge clk); #1;
    check("accept_stb", 64'(mst_stb_o), 64'(1));
    check("accept_busy", 64'(busy_o), 64'(1));
    check("accept_adr", 64'(mst_adr_o), 64'(adr));
    check("accept_dat", mst_dat_o, wdat);
    check("accept_we", 64'(mst_we_o), 64'(we));
    k = 0;
    stb_cycles = 0;
    while (!done_o && k < 40) begin
      if (mst_stb_o && mst_cyc_o) stb_cycles++;
      if (k > 0) begin
        check("hold_adr", 64'(mst_adr_o), 64'(adr));
        check("hold_we", 64'(mst_we_o), 64'(we));
      end
      req_i = 1'($urandom_range(0, 1));
      req_we_i = 1'($urandom_range(0, 1));
      req_adr_i = AW'($urandom);
      req_dat_i = {$urandom, $urandom};
      @(posedge clk); #1;
      k++;
    end
    check("done_latency", 64'(k), 64'(k_exp));
    check("stb_cycles", 64'(stb_cycles), 64'(k_exp));
    check("done_stb_low", 64'({mst_stb_o, mst_cyc_o}), 64'(0));
    check("done_err", 64'(done_err_o), 64'(exp_err));
    check("done_timeout", 64'(done_timeout_o), 64'(exp_to));
    check("done_busy", 64'(busy_o), 64'(1));
    check("rd_dat", rd_dat_o, rd_exp);
    req_i = 1'b1;
    @(posedge clk); #1;
    check("rel_done", 64'({done_o, done_err_o, done_timeout_o}), 64'(0));
    check("rel_busy", 64'(busy_o), 64'(0));
    check("rel_no_accept", 64'(mst_stb_o), 64'(0));
    req_i = 1'b0;
  endtask

  initial begin
    int mode, w, stb_hi, done_cnt, k;
    rst_i = 1'b1; req_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0; req_dat_i = '0;
    mst_ack_i = 1'b0; mst_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({mst_stb_o, mst_cyc_o, mst_we_o, busy_o, done_o, done_err_o, done_timeout_o}), 64'(0));
    check("rst_adr", 64'(mst_adr_o), 64'(0));
    check("rst_dat", mst_dat_o, 64'(0));
    check("rst_rd", rd_dat_o, 64'(0));
    @(negedge clk); rst_i = 1'b0;

    run_txn(1'b0, 16'h0000, 64'h1111, M_ACK, 0, 64'h00000000DEADBABE);
    run_txn(1'b1, 16'h1234, 64'hCAFE0000F00D, M_ERR, 0, 64'h5555);
    run_txn(1'b0, 16'h00A0, 64'h0, M_NONE, 0, 64'h7777);
    run_txn(1'b0, 16'h00B0, 64'h0, M_BOTH, 1, 64'h9999);
    run_txn(1'b0, 16'h00C0, 64'h0, M_ACK, 6, 64'hABCD0006);
    run_txn(1'b0, 16'h00D0, 64'h0, M_ACK, 7, 64'hABCD0007);
    run_txn(1'b1, 16'h00E0, 64'h42, M_ACK, 2, 64'hFFFF);

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 9);
      mode = (mode < 5) ? M_ACK : (mode < 7) ? M_ERR : (mode < 8) ? M_BOTH : M_NONE;
      w = $urandom_range(0, 8);
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom}, mode, w,
              {$urandom, $urandom});
    end

    // req_i held high: each transfer is 2 strobe cycles, RELEASE, IDLE, then re-accept.
    @(negedge clk);
    s_mode = M_ACK; s_wait = 0; req_we_i = 1'b1; req_i = 1'b1;
    @(posedge clk); #1;
    stb_hi = 0; done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (mst_stb_o) stb_hi++;
      if (done_o) done_cnt++;
      req_adr_i = AW'(i);
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    check("b2b_stb_cycles", 64'(stb_hi), 64'(8));
    check("b2b_done_pulses", 64'(done_cnt), 64'(4));
    repeat (3) @(posedge clk);

    // Reset during ACCESS against a silent slave.
    @(negedge clk);
    s_mode = M_NONE; req_we_i = 1'b0; req_adr_i = 16'hBEEF; req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk); #1;
    check("midrst_ctrl", 64'({mst_stb_o, mst_cyc_o, busy_o, done_o}), 64'(0));
    check("midrst_adr", 64'(mst_adr_o), 64'(0));
    rd_exp = '0;
    check("midrst_rd", rd_dat_o, rd_exp);
    @(negedge clk); rst_i = 1'b0;
    done_cnt = 0;
    for (k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done_o) done_cnt++;
    end
    check("midrst_no_done", 64'(done_cnt), 64'(0));
    run_txn(1'b0, 16'h0042, 64'h0, M_ACK, 1, 64'h0123456789ABCDEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
